// File: rtl/pdumper.sv
// Memory dumper: reads a fixed-size region of memory word by word and streams each byte
// out as UART 8N1, low byte of each word first, so a dump can be fed back to the loader.
module pdumper #(
  parameter logic [31:0] DUMP_SIZE    = 32'd524288,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int unsigned CLKS_PER_BIT = 100,
  parameter int unsigned RD_LATENCY   = 1
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic        START,
  output logic [31:0] ADDR,
  output logic        RE,
  input  logic [31:0] RDATA,
  output logic        TXD,
  output logic        BUSY,
  output logic        DONE
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [31:0]   LAT_INIT = 32'(RD_LATENCY);

  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, FIN} state_e;

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic          re_q, re_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [31:0]   waddr_q, waddr_d;
  logic [31:0]   remain_q, remain_d;
  logic [31:0]   lat_q, lat_d;
  logic [31:0]   word_q, word_d;
  logic [2:0]    nbytes_q, nbytes_d;
  logic [1:0]    byte_q, byte_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] clk_q, clk_d;
  logic [7:0]    cur_byte;

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      re_q     <= 1'b0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      waddr_q  <= '0;
      remain_q <= '0;
      lat_q    <= '0;
      word_q   <= '0;
      nbytes_q <= '0;
      byte_q   <= '0;
      bit_q    <= '0;
      clk_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      re_q     <= re_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      waddr_q  <= waddr_d;
      remain_q <= remain_d;
      lat_q    <= lat_d;
      word_q   <= word_d;
      nbytes_q <= nbytes_d;
      byte_q   <= byte_d;
      bit_q    <= bit_d;
      clk_q    <= clk_d;
    end
  end

  always_comb begin
    case (byte_q)
      2'd0:    cur_byte = word_q[7:0];
      2'd1:    cur_byte = word_q[15:8];
      2'd2:    cur_byte = word_q[23:16];
      default: cur_byte = word_q[31:24];
    endcase
  end

  // bit_q: 0 = start bit, 1..8 = data d0..d7, 9 = stop bit
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    re_d     = re_q;
    txd_d    = txd_q;
    busy_d   = busy_q;
    done_d   = done_q;
    waddr_d  = waddr_q;
    remain_d = remain_q;
    lat_d    = lat_q;
    word_d   = word_q;
    nbytes_d = nbytes_q;
    byte_d   = byte_q;
    bit_d    = bit_q;
    clk_d    = clk_q;
    case (state_q)
      IDLE, FIN: begin
        if (START && !busy_q) begin
          busy_d   = 1'b1;
          done_d   = 1'b0;
          remain_d = DUMP_SIZE;
          waddr_d  = BASE_ADDR;
          if (DUMP_SIZE == 32'd0) begin
            state_d = FIN;
          end else begin
            state_d = READ;
            re_d    = 1'b1;
            addr_d  = BASE_ADDR;
          end
        end else if (busy_q) begin
          // Only reachable for an empty dump: finish one cycle after START
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      READ: begin
        re_d    = 1'b0;
        lat_d   = LAT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == 32'd1) begin
          word_d   = RDATA;
          nbytes_d = (remain_q >= 32'd4) ? 3'd4 : remain_q[2:0];
          byte_d   = 2'd0;
          bit_d    = 4'd0;
          clk_d    = '0;
          txd_d    = 1'b0;
          state_d  = SEND;
        end else begin
          lat_d = lat_q - 32'd1;
        end
      end
      SEND: begin
        if (clk_q == CLK_LAST) begin
          clk_d = '0;
          if (bit_q == 4'd9) begin
            if (3'(byte_q) + 3'd1 == nbytes_q) begin
              remain_d = remain_q - 32'(nbytes_q);
              txd_d    = 1'b1;
              if (remain_q == 32'(nbytes_q)) begin
                state_d = FIN;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end else begin
                waddr_d = waddr_q + 32'd4;
                addr_d  = waddr_q + 32'd4;
                re_d    = 1'b1;
                state_d = READ;
              end
            end else begin
              byte_d = byte_q + 2'd1;
              bit_d  = 4'd0;
              txd_d  = 1'b0;
            end
          end else begin
            bit_d = bit_q + 4'd1;
            txd_d = (bit_q == 4'd8) ? 1'b1 : cur_byte[bit_q[2:0]];
          end
        end else begin
          clk_d = clk_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ADDR = addr_q;
    RE   = re_q;
    TXD  = txd_q;
    BUSY = busy_q;
    DONE = done_q;
  end

endmodule

// File: tb/tb_pdumper.sv
// Directed bench for pdumper: four instances cover basic, partial-word, long-latency and
// empty dumps; a UART receiver task decodes TXD and records frame start cycles.
module tb_pdumper;

  localparam int CPB = 4;
  localparam int LAT [4] = '{1, 1, 3, 1};
  localparam logic [7:0] EXP [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  logic        CLK = 1'b0;
  logic        RST_X = 1'b0;
  logic [3:0]  start = '0;
  logic [3:0]  re, txd, busy, done;
  logic [31:0] addr [4];
  logic [31:0] rdata [4];

  int checkCount = 0;
  int errCount = 0;
  int cyc = 0;

  logic [3:0]  vpipe [4];
  logic [31:0] dpipe [4][4];

  int          reCount [4] = '{0, 0, 0, 0};
  logic [31:0] reAddr [4][16];
  int          reCyc [4][16];
  int          doneCyc [4] = '{-1, -1, -1, -1};
  bit          prevDone [4] = '{0, 0, 0, 0};
  bit          txdLow [4] = '{0, 0, 0, 0};
  bit          bothHigh = 1'b0;

  logic [7:0] rxB [16];
  int         rxC [16];

  pdumper #(.DUMP_SIZE(32'd8), .BASE_ADDR(32'h0), .CLKS_PER_BIT(CPB), .RD_LATENCY(1)) u0 (
    .CLK(CLK), .RST_X(RST_X), .START(start[0]), .ADDR(addr[0]), .RE(re[0]),
    .RDATA(rdata[0]), .TXD(txd[0]), .BUSY(busy[0]), .DONE(done[0]));
  pdumper #(.DUMP_SIZE(32'd6), .BASE_ADDR(32'h0), .CLKS_PER_BIT(CPB), .RD_LATENCY(1)) u1 (
    .CLK(CLK), .RST_X(RST_X), .START(start[1]), .ADDR(addr[1]), .RE(re[1]),
    .RDATA(rdata[1]), .TXD(txd[1]), .BUSY(busy[1]), .DONE(done[1]));
  pdumper #(.DUMP_SIZE(32'd8), .BASE_ADDR(32'h0), .CLKS_PER_BIT(CPB), .RD_LATENCY(3)) u2 (
    .CLK(CLK), .RST_X(RST_X), .START(start[2]), .ADDR(addr[2]), .RE(re[2]),
    .RDATA(rdata[2]), .TXD(txd[2]), .BUSY(busy[2]), .DONE(done[2]));
  pdumper #(.DUMP_SIZE(32'd0), .BASE_ADDR(32'h0), .CLKS_PER_BIT(CPB), .RD_LATENCY(1)) u3 (
    .CLK(CLK), .RST_X(RST_X), .START(start[3]), .ADDR(addr[3]), .RE(re[3]),
    .RDATA(rdata[3]), .TXD(txd[3]), .BUSY(busy[3]), .DONE(done[3]));

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0:   memWord = 32'h44332211;
      32'h4:   memWord = 32'h88776655;
      default: memWord = {a[15:0], 16'hA5A5};
    endcase
  endfunction

  // Memory model: RDATA shows the word only in the cycle before the capture edge, garbage otherwise
  always @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (!RST_X) vpipe[i] <= '0;
      else        vpipe[i] <= {vpipe[i][2:0], re[i]};
      dpipe[i][0] <= memWord(addr[i]);
      for (int k = 1; k < 4; k++) dpipe[i][k] <= dpipe[i][k-1];
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rdata[i] = vpipe[i][LAT[i]-1] ? dpipe[i][LAT[i]-1] : 32'hDEADBEEF;
    end
  end

  // Event monitor: read addresses/cycles, DONE rise cycle, any TXD low, BUSY&DONE overlap
  always @(negedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (re[i] === 1'b1) begin
        if (reCount[i] < 16) begin
          reAddr[i][reCount[i]] = addr[i];
          reCyc[i][reCount[i]] = cyc;
        end
        reCount[i]++;
      end
      if (txd[i] === 1'b0) txdLow[i] = 1'b1;
      if (done[i] === 1'b1 && !prevDone[i]) doneCyc[i] = cyc;
      prevDone[i] = (done[i] === 1'b1);
      if (busy[i] === 1'b1 && done[i] === 1'b1) bothHigh = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int i);
    start[i] = 1'b1;
    @(negedge CLK);
    start[i] = 1'b0;
  endtask

  task automatic recvN(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      int w;
      w = 0;
      while (txd[i] !== 1'b0 && w < 400) begin
        @(negedge CLK);
        w++;
      end
      checkOutput("rxStart", 32'(txd[i]), 32'd0);
      rxC[k] = cyc;
      for (int j = 0; j < 8; j++) begin
        repeat (CPB) @(negedge CLK);
        rxB[k][j] = txd[i];
      end
      repeat (CPB) @(negedge CLK);
      checkOutput("rxStop", 32'(txd[i]), 32'd1);
    end
  endtask

  task automatic checkBytes(input string tag, input int n);
    for (int k = 0; k < n; k++) checkOutput(tag, 32'(rxB[k]), 32'(EXP[k]));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int w;
    RST_X = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("rstTxd", 32'(txd[0]), 32'd1);
    checkOutput("rstRe", 32'(re[0]), 32'd0);
    checkOutput("rstBusy", 32'(busy[0]), 32'd0);
    checkOutput("rstDone", 32'(done[0]), 32'd0);
    checkOutput("rstAddr", addr[0], 32'h0);
    RST_X = 1'b1;
    repeat (2) @(negedge CLK);

    $display("[TB] basic dump");
    base = reCount[0];
    applyStimulus(0);
    checkOutput("basicBusy", 32'(busy[0]), 32'd1);
    recvN(0, 8);
    checkBytes("basicByte", 8);
    checkOutput("basicByteSpacing", 32'(rxC[1] - rxC[0]), 32'd40);
    checkOutput("basicWordGap", 32'(rxC[4] - rxC[3]), 32'd42);
    repeat (8) @(negedge CLK);
    checkOutput("basicReads", 32'(reCount[0] - base), 32'd2);
    checkOutput("basicAddr0", reAddr[0][base], 32'h0);
    checkOutput("basicAddr1", reAddr[0][base+1], 32'h4);
    checkOutput("basicDoneCyc", 32'(doneCyc[0]), 32'(rxC[7] + 40));
    checkOutput("basicDone", 32'(done[0]), 32'd1);
    checkOutput("basicBusyEnd", 32'(busy[0]), 32'd0);

    $display("[TB] partial word dump");
    base = reCount[1];
    applyStimulus(1);
    recvN(1, 6);
    checkBytes("partByte", 6);
    repeat (8) @(negedge CLK);
    checkOutput("partReads", 32'(reCount[1] - base), 32'd2);
    checkOutput("partDoneCyc", 32'(doneCyc[1]), 32'(rxC[5] + 40));
    w = 0;
    while (txd[1] === 1'b1 && w < 60) begin
      @(negedge CLK);
      w++;
    end
    checkOutput("partNoExtraByte", 32'(txd[1]), 32'd1);

    $display("[TB] read latency 3");
    base = reCount[2];
    applyStimulus(2);
    recvN(2, 8);
    checkBytes("latByte", 8);
    checkOutput("latWordGap", 32'(rxC[4] - rxC[3]), 32'd44);
    repeat (8) @(negedge CLK);
    checkOutput("latReads", 32'(reCount[2] - base), 32'd2);
    checkOutput("latReadAfterStop", 32'(reCyc[2][base+1]), 32'(rxC[3] + 40));

    $display("[TB] zero size dump");
    applyStimulus(3);
    checkOutput("zeroBusy", 32'(busy[3]), 32'd1);
    checkOutput("zeroDoneLow", 32'(done[3]), 32'd0);
    @(negedge CLK);
    checkOutput("zeroDone", 32'(done[3]), 32'd1);
    checkOutput("zeroBusyEnd", 32'(busy[3]), 32'd0);
    repeat (20) @(negedge CLK);
    checkOutput("zeroReads", 32'(reCount[3]), 32'd0);
    checkOutput("zeroTxdLow", 32'(txdLow[3]), 32'd0);

    $display("[TB] restart after done with ignored mid-dump start");
    base = reCount[0];
    applyStimulus(0);
    checkOutput("againDoneClr", 32'(done[0]), 32'd0);
    checkOutput("againBusy", 32'(busy[0]), 32'd1);
    recvN(0, 2);
    applyStimulus(0);
    for (int k = 2; k < 8; k++) begin
      int c;
      logic [7:0] b;
      recvN(0, 1);
      c = rxC[0];
      b = rxB[0];
      rxC[k] = c;
      rxB[k] = b;
    end
    checkOutput("againByte2", 32'(rxB[2]), 32'(EXP[2]));
    checkOutput("againByte7", 32'(rxB[7]), 32'(EXP[7]));
    checkOutput("againWordGap", 32'(rxC[4] - rxC[3]), 32'd42);
    repeat (8) @(negedge CLK);
    checkOutput("againReads", 32'(reCount[0] - base), 32'd2);
    checkOutput("againDone", 32'(done[0]), 32'd1);

    $display("[TB] reset in the middle of a frame");
    applyStimulus(0);
    recvN(0, 1);
    w = 0;
    while (txd[0] !== 1'b0 && w < 100) begin
      @(negedge CLK);
      w++;
    end
    repeat (2 * CPB) @(negedge CLK);
    checkOutput("midTxdLowBefore", 32'(busy[0]), 32'd1);
    RST_X = 1'b0;
    @(negedge CLK);
    checkOutput("midRstTxd", 32'(txd[0]), 32'd1);
    checkOutput("midRstBusy", 32'(busy[0]), 32'd0);
    checkOutput("midRstDone", 32'(done[0]), 32'd0);
    checkOutput("midRstRe", 32'(re[0]), 32'd0);
    checkOutput("midRstAddr", addr[0], 32'h0);
    RST_X = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("midIdleTxd", 32'(txd[0]), 32'd1);
    base = reCount[0];
    applyStimulus(0);
    recvN(0, 1);
    checkOutput("midRestartByte", 32'(rxB[0]), 32'(EXP[0]));
    checkOutput("midRestartAddr", reAddr[0][base], 32'h0);

    checkOutput("busyDoneOverlap", 32'(bothHigh), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errCount);
    $finish;
  end

endmodule
